elevator_ctrl_n: RTL and testbench
==================================

# elevator_ctrl_n

Parametrised N-floor elevator car controller. Latches floor requests into a pending-call register and serves them in SCAN order: it keeps moving in the current direction while calls remain ahead, then reverses. It times floor-to-floor travel and door dwell with internal counters. It drives the car position, door and status outputs for the floor-display and door-actuator logic.

## Interface
- NUM_FLOORS, 4, number of floors (2..16), numbered 0..NUM_FLOORS-1
- FLOOR_W, 2, width of floor indices; must satisfy 2^FLOOR_W >= NUM_FLOORS
- TRAVEL_CYCLES, 4, clock cycles spent travelling between adjacent floors (>=1)
- DOOR_CYCLES, 3, clock cycles the door stays open per stop (>=1)
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  synchronous, active-high
- req_valid  in  1  request strobe; one request per cycle
- req_floor  in  FLOOR_W  requested floor, sampled when req_valid=1
- current_floor  out  FLOOR_W  floor the car is at or last passed
- door_open  out  1  door open
- moving  out  1  car travelling (state MOVE)
- dir_up  out  1  current/last direction: 1=up, 0=down
- arrive  out  1  one-cycle pulse when current_floor changes
- pending  out  NUM_FLOORS  outstanding calls, bit i = floor i

## Operation
- Reset values: state IDLE, current_floor=0, door_open=0, moving=0, dir_up=1, arrive=0, pending=0, both timers 0.
- Request latch: when req_valid=1 and req_floor<NUM_FLOORS, pending[req_floor] is set at the next edge.
  - req_floor>=NUM_FLOORS is ignored.
  - A request for an already-pending floor has no effect.
- Calls above/below: "above" means any pending bit with index >current_floor; "below" means any with index <current_floor.
- IDLE (door closed, stationary):
  - If pending[current_floor] is set: go to DOOR_OPEN and clear that bit.
  - Else if calls exist in the dir_up direction: go to MOVE, keeping dir_up.
  - Else if calls exist in the opposite direction: toggle dir_up and go to MOVE.
  - Else stay in IDLE.
- MOVE:
  - The travel counter loads TRAVEL_CYCLES-1 on entry and decrements each cycle.
  - When it reaches 0:
    - current_floor updates by +1 (dir_up=1) or -1; arrive pulses with the new floor.
    - If the new floor is pending: go to DOOR_OPEN and clear its bit.
    - Else if calls remain ahead: reload the counter and stay in MOVE.
    - Else go to IDLE.
  - current_floor never leaves 0..NUM_FLOORS-1.
- DOOR_OPEN:
  - door_open=1; the dwell counter loads DOOR_CYCLES-1 on entry.
  - On expiry go to IDLE.
  - A req for current_floor during DOOR_OPEN is not latched and reloads the dwell counter (door re-open).
- Simultaneous events:
  - A req for the floor being cleared in the same cycle (arrival or IDLE service) is absorbed; the bit ends cleared.
  - Requests for other floors latch normally in every state.
- Reset mid-operation: all state returns to reset values at the next edge regardless of state; pending requests are discarded.

## Timing
- Request to pending: 1 cycle.
- IDLE decision: 1 cycle. With pending visible at cycle t in IDLE, moving=1 (or door_open=1) at t+1.
- Per floor travel: exactly TRAVEL_CYCLES cycles in MOVE. current_floor and arrive update together, TRAVEL_CYCLES cycles after moving rises or after the previous arrive.
- door_open rises in the same cycle as the arrive that targets a pending floor. moving drops in that cycle.
- door_open high for exactly DOOR_CYCLES cycles absent re-open; IDLE follows for at least 1 cycle before any MOVE.
- All outputs are registered. pending reflects clears and sets of the same edge.

## Test plan
Defaults apply unless stated (NUM_FLOORS=4, TRAVEL_CYCLES=4, DOOR_CYCLES=3).
- Reset: hold reset 2 cycles -> current_floor=0, door_open=0, moving=0, dir_up=1, pending=4'b0000, arrive=0.
- Single trip: idle at floor 0, req_floor=3 at cycle 0.
  - pending=4'b1000 at cycle 1; moving=1 at cycle 2.
  - arrive with floor 1/2/3 at cycles 6/10/14.
  - door_open=1 and pending=0 at cycle 14, for cycles 14-16; IDLE at cycle 17.
- SCAN priority: car moving up past floor 1 toward 3, req_floor=0 issued.
  - Floor 3 is served first; dir_up toggles to 0 only in IDLE at floor 3; then the car reaches floor 0.
- Local call and re-open:
  - Idle at floor 2, req_floor=2 -> door opens next cycle, moving stays 0.
  - Repeat req_floor=2 on the 2nd door cycle -> door_open held 3 further cycles.
- Range and simultaneity:
  - NUM_FLOORS=3, req_floor=3 -> pending unchanged.
  - req_floor=1 on the arrive cycle at floor 1 -> pending[1]=0 afterward, single stop.
- Reset mid-move: assert reset while moving between floors 1 and 2 with pending=4'b1100 -> next cycle all outputs at reset values, pending=0.

Source files
------------

// File: rtl/elevator_ctrl_n.sv
// SCAN-order elevator car controller: latches floor calls, travels floor by floor
// with a per-floor travel timer, and holds the door open for a dwell period per stop.
module elevator_ctrl_n #(
    parameter int NUM_FLOORS    = 4,
    parameter int FLOOR_W       = 2,
    parameter int TRAVEL_CYCLES = 4,
    parameter int DOOR_CYCLES   = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    input  logic [FLOOR_W-1:0]    req_floor,
    output logic [FLOOR_W-1:0]    current_floor,
    output logic                  door_open,
    output logic                  moving,
    output logic                  dir_up,
    output logic                  arrive,
    output logic [NUM_FLOORS-1:0] pending
);

    localparam int TW = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
    localparam int DW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
    localparam logic [TW-1:0]      TRAVEL_LOAD = TW'(TRAVEL_CYCLES - 1);
    localparam logic [DW-1:0]      DOOR_LOAD   = DW'(DOOR_CYCLES - 1);
    localparam logic [FLOOR_W-1:0] TOP_FLOOR   = FLOOR_W'(NUM_FLOORS - 1);
    localparam logic [FLOOR_W:0]   NF          = (FLOOR_W + 1)'(NUM_FLOORS);

    typedef enum logic [1:0] {IDLE, MOVE, DOOR_OPEN} state_t;

    state_t                  state_q, state_d;
    logic [FLOOR_W-1:0]      floor_q, floor_d;
    logic                    dir_q, dir_d;
    logic                    arrive_q, arrive_d;
    logic [NUM_FLOORS-1:0]   pending_q, pending_d;
    logic [TW-1:0]           travel_q, travel_d;
    logic [DW-1:0]           dwell_q, dwell_d;
    logic [NUM_FLOORS-1:0]   set_v, clr_v;
    logic [FLOOR_W-1:0]      nxt_floor;
    logic                    at_edge;

    function automatic logic [NUM_FLOORS-1:0] onehot(input logic [FLOOR_W-1:0] f);
        logic [NUM_FLOORS-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_FLOORS; i++)
            if (int'(f) == i) r[i] = 1'b1;
        return r;
    endfunction

    // Any pending call strictly beyond floor f in the given direction.
    function automatic logic calls_ahead(input logic [NUM_FLOORS-1:0] p,
                                         input logic [FLOOR_W-1:0] f, input logic up);
        logic r;
        r = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++)
            if (p[i] && (up ? (i > int'(f)) : (i < int'(f)))) r = 1'b1;
        return r;
    endfunction

    always_comb begin
        state_d   = state_q;
        floor_d   = floor_q;
        dir_d     = dir_q;
        arrive_d  = 1'b0;
        travel_d  = travel_q;
        dwell_d   = dwell_q;
        clr_v     = '0;
        set_v     = '0;
        nxt_floor = dir_q ? floor_q + FLOOR_W'(1) : floor_q - FLOOR_W'(1);
        at_edge   = dir_q ? (floor_q == TOP_FLOOR) : (floor_q == '0);

        if (req_valid && ({1'b0, req_floor} < NF)) set_v = onehot(req_floor);

        unique case (state_q)
            IDLE: begin
                if (|(pending_q & onehot(floor_q))) begin
                    state_d = DOOR_OPEN;
                    clr_v   = onehot(floor_q);
                    dwell_d = DOOR_LOAD;
                end else if (calls_ahead(pending_q, floor_q, dir_q)) begin
                    state_d  = MOVE;
                    travel_d = TRAVEL_LOAD;
                end else if (calls_ahead(pending_q, floor_q, !dir_q)) begin
                    state_d  = MOVE;
                    dir_d    = !dir_q;
                    travel_d = TRAVEL_LOAD;
                end
            end
            MOVE: begin
                if (travel_q != '0) begin
                    travel_d = travel_q - TW'(1);
                end else if (at_edge) begin
                    state_d = IDLE;
                end else begin
                    floor_d  = nxt_floor;
                    arrive_d = 1'b1;
                    if (|(pending_q & onehot(nxt_floor))) begin
                        state_d = DOOR_OPEN;
                        clr_v   = onehot(nxt_floor);
                        dwell_d = DOOR_LOAD;
                    end else if (calls_ahead(pending_q, nxt_floor, dir_q)) begin
                        travel_d = TRAVEL_LOAD;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DOOR_OPEN: begin
                // A call for this floor while the door is open re-opens it instead of latching.
                clr_v = onehot(floor_q);
                if (req_valid && (req_floor == floor_q)) dwell_d = DOOR_LOAD;
                else if (dwell_q == '0)                  state_d = IDLE;
                else                                     dwell_d = dwell_q - DW'(1);
            end
            default: state_d = IDLE;
        endcase

        pending_d = (pending_q | set_v) & ~clr_v;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            floor_q   <= '0;
            dir_q     <= 1'b1;
            arrive_q  <= 1'b0;
            pending_q <= '0;
            travel_q  <= '0;
            dwell_q   <= '0;
        end else begin
            state_q   <= state_d;
            floor_q   <= floor_d;
            dir_q     <= dir_d;
            arrive_q  <= arrive_d;
            pending_q <= pending_d;
            travel_q  <= travel_d;
            dwell_q   <= dwell_d;
        end
    end

    assign current_floor = floor_q;
    assign door_open     = (state_q == DOOR_OPEN);
    assign moving        = (state_q == MOVE);
    assign dir_up        = dir_q;
    assign arrive        = arrive_q;
    assign pending       = pending_q;

endmodule

// File: tb/tb_elevator_ctrl_n.sv
// Directed bench for elevator_ctrl_n: 4-floor car for trips/SCAN/door, 3-floor car for range.
module tb_elevator_ctrl_n;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req_valid = 1'b0;
    logic [1:0] req_floor = 2'd0;
    logic [1:0] current_floor;
    logic       door_open, moving, dir_up, arrive;
    logic [3:0] pending;

    logic       reset3 = 1'b1;
    logic       req_valid3 = 1'b0;
    logic [1:0] req_floor3 = 2'd0;
    logic [1:0] cf3;
    logic       door3, mov3, dir3, arr3;
    logic [2:0] pend3;

    int n_cmp = 0;
    int n_err = 0;

    logic [3:0] e_pend;
    logic [1:0] e_fl;
    logic       e_arr, e_door, e_mov, e_dir;

    always #5 clk = ~clk;

    elevator_ctrl_n #(.NUM_FLOORS(4), .FLOOR_W(2), .TRAVEL_CYCLES(4), .DOOR_CYCLES(3)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_floor(req_floor),
        .current_floor(current_floor), .door_open(door_open), .moving(moving),
        .dir_up(dir_up), .arrive(arrive), .pending(pending)
    );

    elevator_ctrl_n #(.NUM_FLOORS(3), .FLOOR_W(2), .TRAVEL_CYCLES(4), .DOOR_CYCLES(3)) dut3 (
        .clk(clk), .reset(reset3), .req_valid(req_valid3), .req_floor(req_floor3),
        .current_floor(cf3), .door_open(door3), .moving(mov3),
        .dir_up(dir3), .arrive(arr3), .pending(pend3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        req_valid = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req_valid = 1'b0;
        tick();
        tick();
        n_cmp++; if (current_floor !== 2'd0) begin n_err++; $display("FAIL reset floor got %0d exp 0", current_floor); end
        n_cmp++; if (door_open !== 1'b0) begin n_err++; $display("FAIL reset door got %b exp 0", door_open); end
        n_cmp++; if (moving !== 1'b0) begin n_err++; $display("FAIL reset moving got %b exp 0", moving); end
        n_cmp++; if (dir_up !== 1'b1) begin n_err++; $display("FAIL reset dir_up got %b exp 1", dir_up); end
        n_cmp++; if (arrive !== 1'b0) begin n_err++; $display("FAIL reset arrive got %b exp 0", arrive); end
        n_cmp++; if (pending !== 4'b0000) begin n_err++; $display("FAIL reset pending got %b exp 0000", pending); end
        reset = 1'b0;
    endtask

    // Floor 0 -> 3: arrivals at 6/10/14, door 14..16, idle at 17.
    task automatic test_single_trip();
        apply_reset();
        req_valid = 1'b1; req_floor = 2'd3;
        for (int c = 1; c <= 18; c++) begin
            tick();
            req_valid = 1'b0;
            e_pend = (c < 14) ? 4'b1000 : 4'b0000;
            e_fl   = (c < 6) ? 2'd0 : (c < 10) ? 2'd1 : (c < 14) ? 2'd2 : 2'd3;
            e_arr  = (c == 6) || (c == 10) || (c == 14);
            e_door = (c >= 14) && (c <= 16);
            e_mov  = (c >= 2) && (c <= 13);
            e_dir  = 1'b1;
            n_cmp++; if (pending !== e_pend) begin n_err++; $display("FAIL trip pending c=%0d got %b exp %b", c, pending, e_pend); end
            n_cmp++; if (current_floor !== e_fl) begin n_err++; $display("FAIL trip floor c=%0d got %0d exp %0d", c, current_floor, e_fl); end
            n_cmp++; if (arrive !== e_arr) begin n_err++; $display("FAIL trip arrive c=%0d got %b exp %b", c, arrive, e_arr); end
            n_cmp++; if (door_open !== e_door) begin n_err++; $display("FAIL trip door c=%0d got %b exp %b", c, door_open, e_door); end
            n_cmp++; if (moving !== e_mov) begin n_err++; $display("FAIL trip moving c=%0d got %b exp %b", c, moving, e_mov); end
            n_cmp++; if (dir_up !== e_dir) begin n_err++; $display("FAIL trip dir_up c=%0d got %b exp %b", c, dir_up, e_dir); end
        end
    endtask

    // Call for floor 0 while passing floor 1 upward: serve 3 first, reverse in IDLE, then 0.
    task automatic test_scan();
        apply_reset();
        req_valid = 1'b1; req_floor = 2'd3;
        for (int c = 1; c <= 34; c++) begin
            tick();
            req_valid = (c == 7); req_floor = 2'd0;
            e_pend = (c < 8) ? 4'b1000 : (c < 14) ? 4'b1001 : (c < 30) ? 4'b0001 : 4'b0000;
            e_fl   = (c < 6) ? 2'd0 : (c < 10) ? 2'd1 : (c < 14) ? 2'd2 : (c < 22) ? 2'd3 :
                     (c < 26) ? 2'd2 : (c < 30) ? 2'd1 : 2'd0;
            e_arr  = (c == 6) || (c == 10) || (c == 14) || (c == 22) || (c == 26) || (c == 30);
            e_door = ((c >= 14) && (c <= 16)) || ((c >= 30) && (c <= 32));
            e_mov  = ((c >= 2) && (c <= 13)) || ((c >= 18) && (c <= 29));
            e_dir  = (c < 18);
            n_cmp++; if (pending !== e_pend) begin n_err++; $display("FAIL scan pending c=%0d got %b exp %b", c, pending, e_pend); end
            n_cmp++; if (current_floor !== e_fl) begin n_err++; $display("FAIL scan floor c=%0d got %0d exp %0d", c, current_floor, e_fl); end
            n_cmp++; if (arrive !== e_arr) begin n_err++; $display("FAIL scan arrive c=%0d got %b exp %b", c, arrive, e_arr); end
            n_cmp++; if (door_open !== e_door) begin n_err++; $display("FAIL scan door c=%0d got %b exp %b", c, door_open, e_door); end
            n_cmp++; if (moving !== e_mov) begin n_err++; $display("FAIL scan moving c=%0d got %b exp %b", c, moving, e_mov); end
            n_cmp++; if (dir_up !== e_dir) begin n_err++; $display("FAIL scan dir_up c=%0d got %b exp %b", c, dir_up, e_dir); end
        end
    endtask

    // Travel to floor 2, then a local call (door opens, no motion) and a re-open on door cycle 2.
    task automatic test_local_reopen();
        apply_reset();
        req_valid = 1'b1; req_floor = 2'd2;
        for (int c = 1; c <= 22; c++) begin
            tick();
            req_valid = (c == 14) || (c == 17); req_floor = 2'd2;
            e_pend = (c < 10) ? 4'b0100 : (c == 15) ? 4'b0100 : 4'b0000;
            e_fl   = (c < 6) ? 2'd0 : (c < 10) ? 2'd1 : 2'd2;
            e_arr  = (c == 6) || (c == 10);
            e_door = ((c >= 10) && (c <= 12)) || ((c >= 16) && (c <= 20));
            e_mov  = (c >= 2) && (c <= 9);
            e_dir  = 1'b1;
            n_cmp++; if (pending !== e_pend) begin n_err++; $display("FAIL local pending c=%0d got %b exp %b", c, pending, e_pend); end
            n_cmp++; if (current_floor !== e_fl) begin n_err++; $display("FAIL local floor c=%0d got %0d exp %0d", c, current_floor, e_fl); end
            n_cmp++; if (arrive !== e_arr) begin n_err++; $display("FAIL local arrive c=%0d got %b exp %b", c, arrive, e_arr); end
            n_cmp++; if (door_open !== e_door) begin n_err++; $display("FAIL local door c=%0d got %b exp %b", c, door_open, e_door); end
            n_cmp++; if (moving !== e_mov) begin n_err++; $display("FAIL local moving c=%0d got %b exp %b", c, moving, e_mov); end
            n_cmp++; if (dir_up !== e_dir) begin n_err++; $display("FAIL local dir_up c=%0d got %b exp %b", c, dir_up, e_dir); end
        end
    endtask

    // 3-floor car: req_floor=3 is out of range and must not latch; floor 2 does.
    task automatic test_range();
        reset3 = 1'b1;
        tick();
        reset3 = 1'b0;
        req_valid3 = 1'b1; req_floor3 = 2'd3;
        tick();
        req_valid3 = 1'b0;
        n_cmp++; if (pend3 !== 3'b000) begin n_err++; $display("FAIL range pending got %b exp 000", pend3); end
        tick();
        n_cmp++; if (mov3 !== 1'b0) begin n_err++; $display("FAIL range moving got %b exp 0", mov3); end
        n_cmp++; if (pend3 !== 3'b000) begin n_err++; $display("FAIL range pending2 got %b exp 000", pend3); end
        req_valid3 = 1'b1; req_floor3 = 2'd2;
        tick();
        req_valid3 = 1'b0;
        n_cmp++; if (pend3 !== 3'b100) begin n_err++; $display("FAIL range latch got %b exp 100", pend3); end
        tick();
        n_cmp++; if (mov3 !== 1'b1) begin n_err++; $display("FAIL range move got %b exp 1", mov3); end
    endtask

    // Calls 1 and 3; a repeat call for 1 on the arrival edge is absorbed -> one stop at 1.
    task automatic test_simultaneous();
        apply_reset();
        req_valid = 1'b1; req_floor = 2'd1;
        for (int c = 1; c <= 21; c++) begin
            tick();
            req_valid = (c == 1) || (c == 5);
            req_floor = (c == 1) ? 2'd3 : 2'd1;
            e_pend = (c == 1) ? 4'b0010 : (c < 6) ? 4'b1010 : (c < 18) ? 4'b1000 : 4'b0000;
            e_fl   = (c < 6) ? 2'd0 : (c < 14) ? 2'd1 : (c < 18) ? 2'd2 : 2'd3;
            e_arr  = (c == 6) || (c == 14) || (c == 18);
            e_door = ((c >= 6) && (c <= 8)) || ((c >= 18) && (c <= 20));
            e_mov  = ((c >= 2) && (c <= 5)) || ((c >= 10) && (c <= 17));
            e_dir  = 1'b1;
            n_cmp++; if (pending !== e_pend) begin n_err++; $display("FAIL simul pending c=%0d got %b exp %b", c, pending, e_pend); end
            n_cmp++; if (current_floor !== e_fl) begin n_err++; $display("FAIL simul floor c=%0d got %0d exp %0d", c, current_floor, e_fl); end
            n_cmp++; if (arrive !== e_arr) begin n_err++; $display("FAIL simul arrive c=%0d got %b exp %b", c, arrive, e_arr); end
            n_cmp++; if (door_open !== e_door) begin n_err++; $display("FAIL simul door c=%0d got %b exp %b", c, door_open, e_door); end
            n_cmp++; if (moving !== e_mov) begin n_err++; $display("FAIL simul moving c=%0d got %b exp %b", c, moving, e_mov); end
            n_cmp++; if (dir_up !== e_dir) begin n_err++; $display("FAIL simul dir_up c=%0d got %b exp %b", c, dir_up, e_dir); end
        end
    endtask

    // Reset while travelling 1 -> 2 with calls 2 and 3 outstanding.
    task automatic test_reset_mid_move();
        apply_reset();
        req_valid = 1'b1; req_floor = 2'd2;
        for (int c = 1; c <= 7; c++) begin
            tick();
            req_valid = (c == 1); req_floor = 2'd3;
            e_pend = (c == 1) ? 4'b0100 : 4'b1100;
            e_mov  = (c >= 2);
            e_fl   = (c < 6) ? 2'd0 : 2'd1;
            n_cmp++; if (pending !== e_pend) begin n_err++; $display("FAIL rmid pending c=%0d got %b exp %b", c, pending, e_pend); end
            n_cmp++; if (moving !== e_mov) begin n_err++; $display("FAIL rmid moving c=%0d got %b exp %b", c, moving, e_mov); end
            n_cmp++; if (current_floor !== e_fl) begin n_err++; $display("FAIL rmid floor c=%0d got %0d exp %0d", c, current_floor, e_fl); end
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_cmp++; if (current_floor !== 2'd0) begin n_err++; $display("FAIL rmid reset floor got %0d exp 0", current_floor); end
        n_cmp++; if (door_open !== 1'b0) begin n_err++; $display("FAIL rmid reset door got %b exp 0", door_open); end
        n_cmp++; if (moving !== 1'b0) begin n_err++; $display("FAIL rmid reset moving got %b exp 0", moving); end
        n_cmp++; if (dir_up !== 1'b1) begin n_err++; $display("FAIL rmid reset dir_up got %b exp 1", dir_up); end
        n_cmp++; if (arrive !== 1'b0) begin n_err++; $display("FAIL rmid reset arrive got %b exp 0", arrive); end
        n_cmp++; if (pending !== 4'b0000) begin n_err++; $display("FAIL rmid reset pending got %b exp 0000", pending); end
        tick();
        n_cmp++; if (moving !== 1'b0) begin n_err++; $display("FAIL rmid after moving got %b exp 0", moving); end
        n_cmp++; if (pending !== 4'b0000) begin n_err++; $display("FAIL rmid after pending got %b exp 0000", pending); end
    endtask

    initial begin
        test_reset();
        test_single_trip();
        test_scan();
        test_local_reopen();
        test_range();
        test_simultaneous();
        test_reset_mid_move();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
